// File: rtl/wb_decode_mux_if.sv
// -----------------------------------------------------------------------------
// wb_decode_mux_if
//
// Bundle of the Wishbone classic signals around wb_decode_mux. It carries
// one master port (wbm_*) and NUM_SLAVES slave ports (wbs_*). Each slave
// vector is flat, and slot i sits at the same index as its MATCH_ADDR slot.
//
// Handshake (Wishbone classic): a request is valid while cyc & stb are
// high. The request must hold until exactly one of ack/err/rty is returned
// in the same cycle. The cycle in which a response is high completes the
// transfer. No separate ready signal exists: the response is the ready.
//
// Modports:
//   slave  : the decoder/mux itself. It is slave to the core's IO master.
//   master : the surrounding fabric (core request side plus peripheral
//            response side). It drives wbm_* requests and wbs_* responses.
// -----------------------------------------------------------------------------
interface wb_decode_mux_if #(
  parameter int NUM_SLAVES = 9
);
  // master request
  logic [31:0]               wbm_adr_i;
  logic [31:0]               wbm_dat_i;
  logic [3:0]                wbm_sel_i;
  logic                      wbm_we_i;
  logic                      wbm_cyc_i;
  logic                      wbm_stb_i;
  logic [2:0]                wbm_cti_i;
  logic [1:0]                wbm_bte_i;
  // master response
  logic [31:0]               wbm_dat_o;
  logic                      wbm_ack_o;
  logic                      wbm_err_o;
  logic                      wbm_rty_o;
  // slave requests
  logic [NUM_SLAVES*32-1:0]  wbs_adr_o;
  logic [NUM_SLAVES*32-1:0]  wbs_dat_o;
  logic [NUM_SLAVES*4-1:0]   wbs_sel_o;
  logic [NUM_SLAVES-1:0]     wbs_we_o;
  logic [NUM_SLAVES-1:0]     wbs_cyc_o;
  logic [NUM_SLAVES-1:0]     wbs_stb_o;
  logic [NUM_SLAVES*3-1:0]   wbs_cti_o;
  logic [NUM_SLAVES*2-1:0]   wbs_bte_o;
  // slave responses
  logic [NUM_SLAVES*32-1:0]  wbs_dat_i;
  logic [NUM_SLAVES-1:0]     wbs_ack_i;
  logic [NUM_SLAVES-1:0]     wbs_err_i;
  logic [NUM_SLAVES-1:0]     wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_decode_mux.sv
// -----------------------------------------------------------------------------
// wb_decode_mux
//
// 1-to-NUM_SLAVES Wishbone classic address decoder and mux for the SweRVolf
// IO bus. The decode is registered. A request seen in IDLE selects the
// lowest-index slave whose (adr & MASK) == ADDR. That slave sees cyc/stb
// from the next cycle on, and its response passes straight back to the
// master. An unmapped address gets a one-cycle err from the mux itself.
//
// Optional feature, enabled by defining WB_DECODE_MUX_TIMEOUT_EN:
// a per-transfer watchdog. It ends a transfer that stays in ACTIVE for
// TIMEOUT_CYCLES cycles with no response. The mux then returns err and
// drops the slave's cyc/stb in that cycle. When the macro is not defined,
// a slave that never responds stalls the bus.
//
// Ports:
//   wb_clk_i      : bus clock, rising edge
//   wb_rst_n_i    : synchronous active-low reset
//   bus           : wb_decode_mux_if.slave (master port + NUM_SLAVES slaves);
//                   the interface NUM_SLAVES must equal this module's
//   bus_err_o     : one-cycle pulse on every mux-generated error
//   bus_err_adr_o : address of the most recent mux-generated error
//   dbg_state_o   : FSM state (0 = IDLE, 1 = ACTIVE, 2 = ERR)
// -----------------------------------------------------------------------------
module wb_decode_mux #(
  parameter int                         NUM_SLAVES     = 9,
  parameter logic [NUM_SLAVES*32-1:0]   MATCH_ADDR     = '0,
  parameter logic [NUM_SLAVES*32-1:0]   MATCH_MASK     = '0,
  parameter int                         TIMEOUT_CYCLES = 1024
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  wb_decode_mux_if.slave        bus,
  output logic                  bus_err_o,
  output logic [31:0]           bus_err_adr_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [31:0]             err_adr_q;

  logic [NUM_SLAVES-1:0]   hit;
  logic [NUM_SLAVES-1:0]   hit_first;
  logic [31:0]             sel_dat;
  logic                    slv_ack, slv_err, slv_rty, slv_resp;
  logic                    timeout;
  logic                    capture;
  logic [NUM_SLAVES-1:0]   cyc_out, stb_out;
  logic [31:0]             m_dat;
  logic                    m_ack, m_err, m_rty;

  // ---------------------------------------------------------------------------
  // Address match and priority. x & (~x + 1) keeps only the lowest set bit,
  // so the lowest index wins when address windows overlap.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = (bus.wbm_adr_i & MATCH_MASK[32*i +: 32]) == MATCH_ADDR[32*i +: 32];
    end
  end

  assign hit_first = hit & (~hit + NUM_SLAVES'(1));

  // Response from the latched slave only; the others are ignored.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_dat = sel_dat | bus.wbs_dat_i[32*i +: 32];
    end
  end

  assign slv_ack  = |(bus.wbs_ack_i & sel_q);
  assign slv_err  = |(bus.wbs_err_i & sel_q);
  assign slv_rty  = |(bus.wbs_rty_i & sel_q);
  assign slv_resp = slv_ack | slv_err | slv_rty;

  // ---------------------------------------------------------------------------
  // Watchdog. The counter holds the number of ACTIVE cycles already spent
  // without a response. At TIMEOUT_CYCLES-1, the current cycle is the last
  // allowed one. A slave response in that same cycle still wins.
  // ---------------------------------------------------------------------------
`ifdef WB_DECODE_MUX_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wd_cnt_q <= '0;
    end else if (state_q != S_ACTIVE) begin
      // Held at zero outside ACTIVE, so every transfer starts from zero.
      wd_cnt_q <= '0;
    end else if (!slv_resp) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end

  // A master abort (cyc low) ends the transfer silently, even in the last cycle.
  assign timeout = (state_q == S_ACTIVE) && bus.wbm_cyc_i && !slv_resp &&
                   (wd_cnt_q == WD_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      err_adr_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (capture) err_adr_q <= bus.wbm_adr_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cyc_out   = '0;
    stb_out   = '0;
    m_dat     = '0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_rty     = 1'b0;
    bus_err_o = 1'b0;
    capture   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
          if (|hit) begin
            sel_d   = hit_first;
            state_d = S_ACTIVE;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_ACTIVE: begin
        if (timeout) begin
          m_err     = 1'b1;
          bus_err_o = 1'b1;
          capture   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cyc_out = sel_q & {NUM_SLAVES{bus.wbm_cyc_i}};
          stb_out = sel_q & {NUM_SLAVES{bus.wbm_stb_i}};
          m_dat   = sel_dat;
          m_ack   = slv_ack;
          m_err   = slv_err;
          m_rty   = slv_rty;
          if (slv_resp || !bus.wbm_cyc_i) state_d = S_IDLE;
        end
      end

      S_ERR: begin
        m_err     = 1'b1;
        bus_err_o = 1'b1;
        capture   = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Request fields go to every slave. Only cyc/stb are steered.
  // ---------------------------------------------------------------------------
  assign bus.wbs_adr_o = {NUM_SLAVES{bus.wbm_adr_i}};
  assign bus.wbs_dat_o = {NUM_SLAVES{bus.wbm_dat_i}};
  assign bus.wbs_sel_o = {NUM_SLAVES{bus.wbm_sel_i}};
  assign bus.wbs_we_o  = {NUM_SLAVES{bus.wbm_we_i}};
  assign bus.wbs_cti_o = {NUM_SLAVES{bus.wbm_cti_i}};
  assign bus.wbs_bte_o = {NUM_SLAVES{bus.wbm_bte_i}};
  assign bus.wbs_cyc_o = cyc_out;
  assign bus.wbs_stb_o = stb_out;

  assign bus.wbm_dat_o = m_dat;
  assign bus.wbm_ack_o = m_ack;
  assign bus.wbm_err_o = m_err;
  assign bus.wbm_rty_o = m_rty;

  assign bus_err_adr_o = err_adr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_wb_decode_mux.sv
// -----------------------------------------------------------------------------
// tb_wb_decode_mux
//
// Four-slot map:
//   slot 0 = 0x0000/0xFFFFF000
//   slot 1 = 0x1000/0xFFFFFFC0
//   slot 2 = 0x2000/0xFFFFF000
//   slot 3 = 0x1000/0xFFFFF000
// Slot 3 overlaps slot 1, so 0x1000-0x103F must pick slot 1.
//
// The driver issues transfers and plays the addressed peripheral. A reference
// decoder predicts each master response (kind, data, cycle) and pushes it to
// exp_q. A separate negedge monitor pops and compares every response the DUT
// presents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_decode_mux;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam logic [N*32-1:0] M_ADDR = {32'h0000_1000, 32'h0000_2000,
                                        32'h0000_1000, 32'h0000_0000};
  localparam logic [N*32-1:0] M_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                        32'hFFFF_FFC0, 32'hFFFF_F000};
  localparam logic [31:0] MAP_ADDR [N] = '{32'h0000_0000, 32'h0000_1000,
                                           32'h0000_2000, 32'h0000_1000};
  localparam logic [31:0] MAP_MASK [N] = '{32'hFFFF_F000, 32'hFFFF_FFC0,
                                           32'hFFFF_F000, 32'hFFFF_F000};
`ifdef WB_DECODE_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc_n = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  wb_decode_mux_if #(.NUM_SLAVES(N)) bus ();
  logic        bus_err;
  logic [31:0] bus_err_adr;
  logic [1:0]  dbg_state;

  wb_decode_mux #(
    .NUM_SLAVES(N), .MATCH_ADDR(M_ADDR), .MATCH_MASK(M_MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus),
    .bus_err_o(bus_err), .bus_err_adr_o(bus_err_adr), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // entry = {bus_err, ack, err, rty, dat[31:0], cycle[31:0]}
  logic [67:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_err_adr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decoder: lowest slot whose masked address matches.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & MAP_MASK[i]) == MAP_ADDR[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [67:0] act;
    logic [67:0] e;
    act = {bus_err, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, bus.wbm_dat_o, cyc_n};
    if (bus.wbm_ack_o || bus.wbm_err_o || bus.wbm_rty_o || bus_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("master_resp", act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_slv();
    bus.wbs_dat_i = '0;
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
    bus.wbs_rty_i = '0;
  endtask

  task automatic clear_mst();
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0; bus.wbm_we_i = 1'b0;
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
  endtask

  // kind = {ack, err, rty} driven by the slave after wait_c wait states;
  // 3'b000 means the slave never responds.
  task automatic do_xfer(input logic [31:0] adr, input logic we, input int wait_c,
                         input logic [2:0] kind, input logic [31:0] sd);
    int          hit, resp_k, k_end;
    bit          to_hit;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [N-1:0] exp_stb;
    int unsigned c0;
    wd  = $urandom();
    sel = 4'($urandom_range(1, 15));
    cti = 3'($urandom_range(0, 7));
    bte = 2'($urandom_range(0, 3));
    hit = ref_decode(adr);
    to_hit = 1'b0;
    if (hit < 0) begin
      k_end = 1;
    end else begin
      resp_k = (kind == 3'b000) ? 1000 : 1 + wait_c;
      if (TO_EN && resp_k > TO) begin
        k_end  = TO;
        to_hit = 1'b1;
      end else begin
        k_end = resp_k;
      end
    end

    @(posedge clk); #1;
    c0 = cyc_n;
    bus.wbm_adr_i = adr; bus.wbm_dat_i = wd; bus.wbm_sel_i = sel; bus.wbm_we_i = we;
    bus.wbm_cti_i = cti; bus.wbm_bte_i = bte; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
    if (hit < 0 || to_hit) exp_q.push_back({1'b1, 3'b010, 32'h0, 32'(c0 + k_end)});
    else                   exp_q.push_back({1'b0, kind, sd, 32'(c0 + k_end)});

    for (int k = 1; k <= k_end; k++) begin
      @(posedge clk); #1;
      clear_slv();
      if (hit >= 0 && !to_hit && k == k_end) begin
        bus.wbs_dat_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.wbs_dat_i[32*hit +: 32] = sd;
        bus.wbs_ack_i[hit] = kind[2];
        bus.wbs_err_i[hit] = kind[1];
        bus.wbs_rty_i[hit] = kind[0];
      end
      @(negedge clk);
      exp_stb = (hit >= 0 && !(to_hit && k == k_end)) ? (N'(1) << hit) : '0;
      check("slave_stb", bus.wbs_stb_o, exp_stb);
      check("slave_cyc", bus.wbs_cyc_o, exp_stb);
      if (k == 1) begin
        check("bcast_adr", bus.wbs_adr_o, {N{adr}});
        check("bcast_dat", bus.wbs_dat_o, {N{wd}});
        check("bcast_ctl", {bus.wbs_sel_o, bus.wbs_we_o, bus.wbs_cti_o, bus.wbs_bte_o},
                           {{N{sel}}, {N{we}}, {N{cti}}, {N{bte}}});
      end
    end

    @(posedge clk); #1;
    clear_mst();
    clear_slv();
    if (hit < 0 || to_hit) last_err_adr = adr;
    @(negedge clk);
    check("err_adr", bus_err_adr, last_err_adr);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] bases [5];
    logic [2:0]  kd;
    int          wt, r;
    bases = '{32'h0000_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_2000, 32'h0000_5000};

    rst_n = 1'b0;
    clear_mst();
    clear_slv();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_slave", {bus.wbs_cyc_o, bus.wbs_stb_o}, '0);
    check("rst_master", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, bus_err}, '0);
    check("rst_err_adr", bus_err_adr, 32'h0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed
    do_xfer(32'h0000_1004, 1'b0, 2, 3'b100, 32'hDEAD_BEEF);  // ack in cycle 3
    do_xfer(32'h0000_1008, 1'b1, 0, 3'b100, 32'h1234_5678);  // zero-wait write
    do_xfer(32'h0000_1000, 1'b0, 1, 3'b100, 32'hA5A5_0001);  // overlap -> slot 1
    do_xfer(32'h0000_1040, 1'b0, 1, 3'b100, 32'hA5A5_0003);  // past slot 1 -> slot 3
    do_xfer(32'h0000_5000, 1'b0, 0, 3'b100, 32'h0);          // unmapped
    do_xfer(32'h0000_0010, 1'b0, 1, 3'b010, 32'hBAD0_0000);  // slave err passes through
    do_xfer(32'h0000_2FFC, 1'b1, 0, 3'b001, 32'h0000_0077);  // slave rty
    do_xfer(32'h0000_2010, 1'b0, 9, 3'b100, 32'h0BAD_F00D);  // long wait
`ifdef WB_DECODE_MUX_TIMEOUT_EN
    do_xfer(32'h0000_2000, 1'b0, 0, 3'b000, 32'h0);          // never acks -> timeout
    do_xfer(32'h0000_2004, 1'b0, TO - 1, 3'b100, 32'hC0DE_0008); // ack in last cycle wins
`endif

    // reset during a stalled transfer
    @(posedge clk); #1;
    bus.wbm_adr_i = 32'h0000_2020; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
    @(posedge clk); #1;                 // cycle 1
    @(posedge clk); #1; rst_n = 1'b0;   // cycle 2
    @(posedge clk); #1; clear_mst();    // cycle 3
    last_err_adr = '0;
    @(negedge clk);
    check("midrst_slave", {bus.wbs_cyc_o, bus.wbs_stb_o}, '0);
    check("midrst_master", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, bus_err}, '0);
    check("midrst_err_adr", bus_err_adr, 32'h0);
    check("midrst_state", dbg_state, 2'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    do_xfer(32'h0000_0020, 1'b0, 1, 3'b100, 32'h5555_AAAA);

    // randomized
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 5);
      a = (r == 5) ? 32'($urandom()) : (bases[r] | 32'($urandom_range(0, 'hFFF)));
      r = $urandom_range(0, 5);
      kd = (r < 4) ? 3'b100 : (r == 4) ? 3'b010 : 3'b001;
      wt = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3);
`ifdef WB_DECODE_MUX_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) kd = 3'b000;
`endif
      do_xfer(a, 1'($urandom_range(0, 1)), wt, kd, $urandom());
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_decode_mux.md
# wb_decode_mux

Parametrised 1-to-N Wishbone classic address decoder/mux for the SweRVolf IO bus, sitting between the core's IO master port and the peripheral slaves (ROM, sys, SPI, UART, GPIO, PTC, I2C, accelerators). It generalises the fixed slave list to `NUM_SLAVES` with a registered decode stage. It adds an error response for unmapped addresses and, optionally, a per-transfer watchdog that terminates stalled transfers with `err` and records the faulting address.

## Interface
- `NUM_SLAVES`, 9: number of slave ports, 1..32.
- `MATCH_ADDR`, 0: `NUM_SLAVES*32`-bit flat vector; slot i = bits [32*i+31:32*i].
- `MATCH_MASK`, 0: same layout; slave i hits when `(adr & MASK_i) == ADDR_i`.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in ACTIVE cycles, 2..65535.

Ports:
- `wb_clk_i` in 1: bus clock; all logic rising-edge.
- `wb_rst_n_i` in 1: reset, synchronous, active-low.
- `wbm_adr_i`/`wbm_dat_i` in 32, `wbm_sel_i` in 4, `wbm_we_i`/`wbm_cyc_i`/`wbm_stb_i` in 1, `wbm_cti_i` in 3, `wbm_bte_i` in 2: master request.
- `wbm_dat_o` out 32, `wbm_ack_o`/`wbm_err_o`/`wbm_rty_o` out 1: master response.
- `wbs_adr_o`/`wbs_dat_o` out `32*N`, `wbs_sel_o` out `4*N`, `wbs_we_o`/`wbs_cyc_o`/`wbs_stb_o` out N, `wbs_cti_o` out `3*N`, `wbs_bte_o` out `2*N`: slave requests, slot i at the same index as `MATCH_ADDR`.
- `wbs_dat_i` in `32*N`, `wbs_ack_i`/`wbs_err_i`/`wbs_rty_i` in N: slave responses.
- `bus_err_o` out 1: one-cycle pulse on any mux-generated error.
- `bus_err_adr_o` out 32: address of the last mux-generated error; holds until the next error.

## Operation
- FSM states: IDLE, ACTIVE, ERR.
- IDLE: on `wbm_cyc_i & wbm_stb_i`, evaluate all matches.
  - Lowest index among hits wins; latch it as `sel_q` (one-hot) and go to ACTIVE.
  - No hit: go to ERR.
- ACTIVE:
  - Every slave gets `adr/dat/sel/we/cti/bte` broadcast.
  - Only slave `sel_q` gets `cyc = wbm_cyc_i` and `stb = wbm_stb_i`; all others get 0.
  - `wbm_dat_o/ack/err/rty` = selected slave's signals, passed through combinationally.
  - Any of ack/err/rty from the selected slave returns the FSM to IDLE.
  - `wbm_cyc_i` low returns the FSM to IDLE (master abort); no response is generated.
- ERR:
  - `wbm_err_o` = 1 for exactly one cycle, `wbm_dat_o` = 0.
  - `bus_err_o` pulses; `bus_err_adr_o` <= `wbm_adr_i`.
  - Then IDLE.
- Watchdog: 16-bit counter, cleared on entering ACTIVE, incremented each ACTIVE cycle without a slave response. Counter value `TIMEOUT_CYCLES-1` with no response:
  - `wbm_err_o` = 1 that cycle, `bus_err_o` pulses, address is captured.
  - Slave `cyc/stb` are forced to 0 that cycle; FSM goes to IDLE.
- Slave response in the same cycle as timeout: the slave response wins; no `bus_err_o`.
- Bursts (`cti` != 0): each beat is handled as a classic transfer. It re-decodes through IDLE, so there is one idle cycle per beat.
- Outside ACTIVE: all `wbs_cyc_o/stb_o` = 0; master ack/rty = 0; `wbm_dat_o` = 0.

## Timing
- Reset (`wb_rst_n_i` = 0 at a clock edge):
  - FSM to IDLE; `sel_q`, counter, `bus_err_o` and `bus_err_adr_o` all go to 0.
  - All `wbs_cyc_o/stb_o` and `wbm_ack/err/rty_o` are 0 from the next cycle.
  - An in-flight transfer is dropped silently.
- Decode latency: request seen at edge 0; slave `cyc/stb` high from cycle 1.
- Response latency to master = 1 + slave latency. A zero-wait slave ack in cycle 1 gives `wbm_ack_o` in cycle 1.
- Unmapped address: `wbm_err_o` in cycle 1.
- Timeout: `wbm_err_o` in cycle `TIMEOUT_CYCLES` after the request edge.
- `bus_err_adr_o` updates on the edge ending the error cycle.
- Max throughput: one transfer per 2 cycles.

## Configuration
- `WB_DECODE_MUX_TIMEOUT_EN` defined: watchdog, counter and timeout error path are compiled in.
- Not defined:
  - Counter and timeout logic are absent; a non-responding slave stalls the bus indefinitely.
  - `bus_err_o`/`bus_err_adr_o` report unmapped accesses only.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- N=3 with maps 0x0000/0xFFFFF000, 0x1000/0xFFFFFFC0, 0x2000/0xFFFFF000. Read 0x1004 with slave 1 acking after 2 cycles, data 0xDEADBEEF → only `wbs_stb_o[1]` high from cycle 1; `wbm_ack_o` in cycle 3 with 0xDEADBEEF.
- Write to 0x1008 → data and `sel` reach slave 1 with `we` = 1; slaves 0 and 2 see `cyc` = 0 throughout.
- Overlapping maps, slot 0 = 0x0000/0xFFFF0000 and slot 1 = 0x1000/0xFFFFF000. Access 0x1000 → slot 0 is selected.
- Access 0x5000 (unmapped) → `wbm_err_o` for exactly one cycle in cycle 1; `bus_err_adr_o` = 0x5000; no slave `cyc`.
- With `WB_DECODE_MUX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never acks:
  - `wbm_err_o` in cycle 8 and slave `stb` drops.
  - Rerun with ack in that same cycle → ack only, no `bus_err_o`.
- Reset asserted in cycle 2 of a stalled transfer → all `cyc/stb/ack/err` are 0 from the next cycle; the next access decodes normally.
